io_port_ctrl: RTL and testbench



---
 rtl/io_port_ctrl_pkg.sv | 13 +
 rtl/io_port_ctrl_if.sv | 34 +++
 rtl/io_port_ctrl_sync_fifo.sv | 72 +++++++
 rtl/io_port_ctrl.sv | 82 ++++++++
 tb/tb_io_port_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/io_port_ctrl_pkg.sv
// Shared constants and interrupt FSM encoding for the I/O port controller.
package io_pkg;

  localparam int IO_W     = 16;
  localparam int IO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/io_port_ctrl_if.sv
// Core- and device-facing signals of the I/O port controller.
interface io_port_ctrl_if #(
  parameter int W = 16
);

  logic [W-1:0] out_port;
  logic         out_strobe;
  logic [W-1:0] in_port;
  logic         in_ack;
  logic         interrupt;
  logic         irq_done;
  logic [W-1:0] dev_out_data;
  logic         dev_out_valid;
  logic         dev_out_ready;
  logic [W-1:0] dev_in_data;
  logic         dev_in_valid;
  logic         dev_in_ready;
  logic         dev_irq;
  logic         ovf;
  logic         unf;

  modport slave (
    input  out_port, out_strobe, in_ack, irq_done,
    input  dev_out_ready, dev_in_data, dev_in_valid, dev_irq,
    output in_port, interrupt, dev_out_data, dev_out_valid, dev_in_ready, ovf, unf
  );

  modport master (
    output out_port, out_strobe, in_ack, irq_done,
    output dev_out_ready, dev_in_data, dev_in_valid, dev_irq,
    input  in_port, interrupt, dev_out_data, dev_out_valid, dev_in_ready, ovf, unf
  );

endinterface

// File: rtl/io_port_ctrl_sync_fifo.sv
// Single-clock FIFO; head reads zero when empty, a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo
  import io_pkg::*;
#(
  parameter int W     = IO_W,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// I/O pin controller: output/input word FIFOs, sticky error flags and the
// device interrupt pulse generator.
//
//   state   | meaning
//   IDLE    | waiting for a 0->1 edge on dev_irq
//   PULSE   | interrupt high for this single cycle
//   SERVICE | handler running; edges ignored until irq_done
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int W     = IO_W,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  io_port_ctrl_if.slave bus
);

  irq_state_e state_q, state_d;
  logic       irq_prev_q, irq_prev_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic       out_full, out_empty;
  logic       in_full, in_empty;

  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.out_strobe),
    .push_data (bus.out_port),
    .pop       (bus.dev_out_ready),
    .head      (bus.dev_out_data),
    .full      (out_full),
    .empty     (out_empty)
  );

  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.dev_in_valid && !in_full),
    .push_data (bus.dev_in_data),
    .pop       (bus.in_ack),
    .head      (bus.in_port),
    .full      (in_full),
    .empty     (in_empty)
  );

  assign bus.dev_out_valid = !out_empty;
  assign bus.dev_in_ready  = !in_full;
  assign bus.interrupt     = (state_q == PULSE);
  assign bus.ovf           = ovf_q;
  assign bus.unf           = unf_q;

  always_comb begin
    state_d    = state_q;
    irq_prev_d = bus.dev_irq;
    // A full output FIFO is never empty, so ready alone means a pop frees a slot.
    ovf_d      = ovf_q | (bus.out_strobe && out_full && !bus.dev_out_ready);
    unf_d      = unf_q | (bus.in_ack && in_empty);
    case (state_q)
      IDLE:    if (bus.dev_irq && !irq_prev_q) state_d = PULSE;
      PULSE:   state_d = SERVICE;
      SERVICE: if (bus.irq_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      irq_prev_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed and randomized bench for io_port_ctrl against a queue-based reference model.
module tb_io_port_ctrl;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_port_ctrl_if #(.W(W)) bus ();

  io_port_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] oq [$];
  logic [W-1:0] iq [$];
  bit m_ovf, m_unf, m_prev, m_pulse, m_busy;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    oq.delete();
    iq.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_prev  = 1'b0;
    m_pulse = 1'b0;
    m_busy  = 1'b0;
  endfunction

  task automatic check_outputs();
    check_eq("dev_out_valid", W'(bus.dev_out_valid), W'(oq.size() > 0));
    check_eq("dev_out_data",  bus.dev_out_data, (oq.size() > 0) ? oq[0] : '0);
    check_eq("dev_in_ready",  W'(bus.dev_in_ready), W'(iq.size() < DEPTH));
    check_eq("in_port",       bus.in_port, (iq.size() > 0) ? iq[0] : '0);
    check_eq("interrupt",     W'(bus.interrupt), W'(m_pulse));
    check_eq("ovf",           W'(bus.ovf), W'(m_ovf));
    check_eq("unf",           W'(bus.unf), W'(m_unf));
  endtask

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    bit pop_o, push_o, push_i, pop_i;
    if (rst) begin
      model_reset();
    end else begin
      pop_o  = bus.dev_out_ready && (oq.size() > 0);
      push_o = bus.out_strobe && ((oq.size() < DEPTH) || pop_o);
      if (bus.out_strobe && (oq.size() == DEPTH) && !pop_o) m_ovf = 1'b1;
      push_i = bus.dev_in_valid && (iq.size() < DEPTH);
      pop_i  = bus.in_ack && (iq.size() > 0);
      if (bus.in_ack && (iq.size() == 0)) m_unf = 1'b1;
      if (pop_o) void'(oq.pop_front());
      if (push_o) oq.push_back(bus.out_port);
      if (pop_i) void'(iq.pop_front());
      if (push_i) iq.push_back(bus.dev_in_data);
      if (m_pulse) begin
        m_pulse = 1'b0;
        m_busy  = 1'b1;
      end else if (m_busy) begin
        if (bus.irq_done) m_busy = 1'b0;
      end else if (bus.dev_irq && !m_prev) begin
        m_pulse = 1'b1;
      end
      m_prev = bus.dev_irq;
    end
  endtask

  task automatic tick();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit os, input logic [W-1:0] od, input bit ia, input bit dv,
                        input logic [W-1:0] dd, input bit dr, input bit irq, input bit done);
    bus.out_strobe    = os;
    bus.out_port      = od;
    bus.in_ack        = ia;
    bus.dev_in_valid  = dv;
    bus.dev_in_data   = dd;
    bus.dev_out_ready = dr;
    bus.dev_irq       = irq;
    bus.irq_done      = done;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst = 1'b0;

    // Output FIFO fill, overflow, drain
    for (int i = 1; i <= 4; i++) begin
      set_in(1, W'(i), 0, 0, 0, 0, 0, 0);
      tick();
    end
    check_eq("tp1_valid_full", W'(bus.dev_out_valid), W'(1));
    set_in(1, 16'h0005, 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("tp1_ovf", W'(bus.ovf), W'(1));
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0);
      check_eq("tp1_drain", bus.dev_out_data, W'(i));
      tick();
    end
    check_eq("tp1_valid_empty", W'(bus.dev_out_valid), W'(0));

    // Input FIFO read and underflow
    set_in(0, 0, 0, 1, 16'hBEEF, 0, 0, 0);
    tick();
    check_eq("tp2_beef", bus.in_port, 16'hBEEF);
    set_in(0, 0, 0, 1, 16'hCAFE, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    check_eq("tp2_cafe", bus.in_port, 16'hCAFE);
    tick();
    check_eq("tp2_zero", bus.in_port, 16'h0000);
    tick();
    check_eq("tp2_unf", W'(bus.unf), W'(1));
    check_eq("tp2_zero2", bus.in_port, 16'h0000);

    // Input FIFO full with concurrent ack and held valid, across pointer wrap
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1, W'(16'h0100 + i), 0, 0, 0);
      tick();
    end
    check_eq("tp3_full_ready", W'(bus.dev_in_ready), W'(0));
    for (int i = 4; i < 10; i++) begin
      set_in(0, 0, 1, 1, W'(16'h0100 + i), 0, 0, 0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_in(0, 0, 1, 0, 0, 0, 0, 0);
      tick();
    end

    // Interrupt pulse, edges ignored in service, re-arm after irq_done
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    check_eq("tp4_pulse", W'(bus.interrupt), W'(1));
    tick();
    check_eq("tp4_one_cycle", W'(bus.interrupt), W'(0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    check_eq("tp4_no_pulse_service", W'(bus.interrupt), W'(0));
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    check_eq("tp4_rearm", W'(bus.interrupt), W'(1));
    tick();

    // dev_irq held high through irq_done
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) tick();
    check_eq("tp5_held_no_pulse", W'(bus.interrupt), W'(0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    check_eq("tp5_new_edge", W'(bus.interrupt), W'(1));
    tick();

    // Reset mid-service with both FIFOs occupied
    set_in(1, 16'h1111, 0, 1, 16'h2222, 0, 1, 0);
    tick();
    set_in(1, 16'h3333, 0, 1, 16'h4444, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("tp6_in_port", bus.in_port, 16'h0000);
    check_eq("tp6_ready", W'(bus.dev_in_ready), W'(1));
    check_eq("tp6_valid", W'(bus.dev_out_valid), W'(0));
    check_eq("tp6_ovf", W'(bus.ovf), W'(0));
    check_eq("tp6_unf", W'(bus.unf), W'(0));
    check_eq("tp6_int", W'(bus.interrupt), W'(0));
    tick();
    check_eq("tp6_held_after_rst", W'(bus.interrupt), W'(1));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 2) != 0,
             ($urandom_range(0, 7) == 0) ? !bus.dev_irq : bus.dev_irq,
             $urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
